// File: rtl/sample_text_writer.sv
// sample_text_writer: buffers signed 22-bit samples and streams each one as a decimal ASCII line.
// Defining SAMPLE_TEXT_WRITER_CRLF_EN ends each line with CR LF; otherwise lines end with LF only.
module sample_text_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [21:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic [31:0] line_count
);
    localparam int AW = $clog2(DEPTH);
`ifdef SAMPLE_TEXT_WRITER_CRLF_EN
    localparam logic [7:0] TERM_FIRST = 8'h0D;
`else
    localparam logic [7:0] TERM_FIRST = 8'h0A;
`endif

    typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, TERM} state_t;

    state_t        state;
    logic [21:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push, pop, empty, full, xfer;
    logic          neg;
    logic [21:0]   mag, head;
    logic [27:0]   bcd, bcd_adj, bcd_next;
    logic [4:0]    step;
    logic [2:0]    idx, first;

    function automatic logic [27:0] dabble(input logic [27:0] b);
        logic [27:0] r;
        for (int i = 0; i < 7; i++)
            r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction

    // Index of the most significant non-zero digit; digit 0 is always printed.
    function automatic logic [2:0] lead(input logic [27:0] b);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 1; i < 7; i++)
            if (b[4*i +: 4] != 4'd0) r = 3'(i);
        return r;
    endfunction

    function automatic logic [7:0] digit(input logic [27:0] b, input logic [2:0] i);
        return {4'h3, b[4*i +: 4]};
    endfunction

    assign empty    = cnt == '0;
    assign full     = cnt == (AW+1)'(DEPTH);
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;
    assign pop      = state == IDLE && !empty;
    assign busy     = state != IDLE || !empty;
    assign xfer     = out_valid && out_ready;
    assign head     = mem[rp];
    assign bcd_adj  = dabble(bcd);
    assign bcd_next = {bcd_adj[26:0], mag[21]};
    assign first    = lead(bcd_next);

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            neg        <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            step       <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            line_count <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    neg   <= head[21];
                    mag   <= head[21] ? 22'(-head) : head;
                    bcd   <= '0;
                    step  <= '0;
                    state <= CONV;
                end
                CONV: begin
                    bcd  <= bcd_next;
                    mag  <= {mag[20:0], 1'b0};
                    step <= step + 5'd1;
                    if (step == 5'd21) begin
                        idx       <= first;
                        out_valid <= 1'b1;
                        state     <= neg ? SIGN : DIGIT;
                        out_data  <= neg ? 8'h2D : digit(bcd_next, first);
                    end
                end
                SIGN: if (xfer) begin
                    state    <= DIGIT;
                    out_data <= digit(bcd, idx);
                end
                DIGIT: if (xfer) begin
                    if (idx == 3'd0) begin
                        state    <= TERM;
                        out_data <= TERM_FIRST;
                    end else begin
                        idx      <= idx - 3'd1;
                        out_data <= digit(bcd, idx - 3'd1);
                    end
                end
                TERM: if (xfer) begin
                    if (out_data == 8'h0A) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        out_data   <= 8'h00;
                        line_count <= line_count + 32'd1;
                    end else begin
                        out_data <= 8'h0A;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_text_writer.sv
// tb_sample_text_writer: directed self-checking bench for sample_text_writer.
// Honours SAMPLE_TEXT_WRITER_CRLF_EN to expect CR LF line endings.
module tb_sample_text_writer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic [31:0] line_count;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  rx [0:255];
    int          rx_cnt;
    int          unstable;
    string       term;

    sample_text_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .line_count(line_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [21:0] v);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int c = 0; c < 300 && !done; c++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL push_timeout: sample %0h accepted=0 required=1", v);
        end
    endtask

    // Collects n bytes with out_ready high one cycle in every `period`, noting any change while stalled.
    task automatic recv(input int n, input int period);
        logic [7:0] held = 8'h00;
        bit hold = 0;
        rx_cnt   = 0;
        unstable = 0;
        for (int c = 0; c < 3000 && rx_cnt < n; c++) begin
            out_ready = (c % period) == 0;
            if (hold && (out_valid !== 1'b1 || out_data !== held)) unstable++;
            if (out_valid && out_ready) begin
                rx[rx_cnt] = out_data;
                rx_cnt++;
                hold = 0;
            end else if (out_valid) begin
                hold = 1;
                held = out_data;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready_low: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (line_count !== 32'd0) begin fails++; $display("FAIL rst_line_count: got %0d want 0", line_count); end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready_high: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_zero();
        string exp = {"0", term};
        int n = 0;
        push(22'd0);
        out_ready = 1'b1;
        for (int c = 1; c < 100 && n == 0; c++) begin
            tick();
            if (out_valid) n = c;
        end
        checks++; if (n != 23) begin fails++; $display("FAIL zero_latency: got %0d cycles want 23", n); end
        recv(exp.len(), 1);
        checks++; if (rx_cnt != exp.len()) begin fails++; $display("FAIL zero_count: got %0d bytes want %0d", rx_cnt, exp.len()); end
        for (int i = 0; i < rx_cnt; i++) begin
            checks++; if (rx[i] !== exp[i]) begin fails++; $display("FAIL zero_byte%0d: got %h want %h", i, rx[i], exp[i]); end
        end
        checks++; if (line_count !== 32'd1) begin fails++; $display("FAIL zero_lines: got %0d want 1", line_count); end
    endtask

    task automatic test_extremes();
        string exp = {"-2097152", term, "2097151", term};
        push(22'h200000);
        push(22'h1FFFFF);
        recv(exp.len(), 1);
        checks++; if (rx_cnt != exp.len()) begin fails++; $display("FAIL ext_count: got %0d bytes want %0d", rx_cnt, exp.len()); end
        for (int i = 0; i < rx_cnt; i++) begin
            checks++; if (rx[i] !== exp[i]) begin fails++; $display("FAIL ext_byte%0d: got %h want %h", i, rx[i], exp[i]); end
        end
        checks++; if (line_count !== 32'd3) begin fails++; $display("FAIL ext_lines: got %0d want 3", line_count); end
    endtask

    task automatic test_stall();
        string exp = {"7", term};
        push(22'd7);
        recv(exp.len(), 3);
        checks++; if (unstable != 0) begin fails++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
        checks++; if (rx_cnt != exp.len()) begin fails++; $display("FAIL stall_count: got %0d bytes want %0d", rx_cnt, exp.len()); end
        for (int i = 0; i < rx_cnt; i++) begin
            checks++; if (rx[i] !== exp[i]) begin fails++; $display("FAIL stall_byte%0d: got %h want %h", i, rx[i], exp[i]); end
        end
        checks++; if (line_count !== 32'd4) begin fails++; $display("FAIL stall_lines: got %0d want 4", line_count); end
    endtask

    task automatic test_ten();
        string exp = {"10", term};
        push(22'd10);
        recv(exp.len(), 1);
        checks++; if (rx_cnt != exp.len()) begin fails++; $display("FAIL ten_count: got %0d bytes want %0d", rx_cnt, exp.len()); end
        for (int i = 0; i < rx_cnt; i++) begin
            checks++; if (rx[i] !== exp[i]) begin fails++; $display("FAIL ten_byte%0d: got %h want %h", i, rx[i], exp[i]); end
        end
        checks++; if (line_count !== 32'd5) begin fails++; $display("FAIL ten_lines: got %0d want 5", line_count); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] vals [6] = '{22'd11, 22'd22, 22'd33, 22'd44, 22'd55, 22'd66};
        string exp = {"11", term, "22", term, "33", term, "44", term, "55", term, "66", term};
        int acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = vals[acc];
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (acc != DEPTH + 1) begin fails++; $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH + 1); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b want 1", busy); end
        fork
            push(vals[5]);
            recv(exp.len(), 1);
        join
        checks++; if (rx_cnt != exp.len()) begin fails++; $display("FAIL bp_count: got %0d bytes want %0d", rx_cnt, exp.len()); end
        for (int i = 0; i < rx_cnt; i++) begin
            checks++; if (rx[i] !== exp[i]) begin fails++; $display("FAIL bp_byte%0d: got %h want %h", i, rx[i], exp[i]); end
        end
        checks++; if (line_count !== 32'd11) begin fails++; $display("FAIL bp_lines: got %0d want 11", line_count); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        push(22'h3FFFD3);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && n == 0; c++) begin
            if (out_valid) n = 1; else tick();
        end
        checks++; if (out_data !== 8'h2D) begin fails++; $display("FAIL mid_sign: got %h want 2d", out_data); end
        tick();
        checks++; if (out_data !== 8'h34) begin fails++; $display("FAIL mid_digit: got %h want 34", out_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL mid_out_data: got %h want 00", out_data); end
        checks++; if (line_count !== 32'd0) begin fails++; $display("FAIL mid_lines: got %0d want 0", line_count); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL mid_no_bytes: got %0d valid cycles want 0", seen); end
        checks++; if (line_count !== 32'd0) begin fails++; $display("FAIL mid_lines_after: got %0d want 0", line_count); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    endtask

    initial begin
`ifdef SAMPLE_TEXT_WRITER_CRLF_EN
        term = "\r\n";
`else
        term = "\n";
`endif
        test_reset();
        test_zero();
        test_extremes();
        test_stall();
        test_ten();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sample_text_writer.md
SAMPLE_TEXT_WRITER -- requirements
Module: sample_text_writer

Interface
REQ-001: Parameter DEPTH, default 4, SHALL set input FIFO depth in samples (power of two, >=2).
REQ-002: clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-004: in_valid  input  1  SHALL indicate in_data holds a sample.
REQ-005: in_ready  output  1  SHALL indicate FIFO can accept a sample this cycle.
REQ-006: in_data  input  22  SHALL carry a signed two's-complement sample.
REQ-007: out_valid  output  1  SHALL indicate out_data holds a text byte.
REQ-008: out_ready  input  1  SHALL indicate the sink accepts out_data this cycle.
REQ-009: out_data  output  8  SHALL carry one ASCII byte of the decimal text stream.
REQ-010: busy  output  1  SHALL be high whenever FSM is not IDLE or FIFO is non-empty.
REQ-011: line_count  output  32  SHALL count fully emitted lines, wrapping 0xFFFFFFFF -> 0.

Function
REQ-012: Each sample SHALL be emitted as one line: optional '-' (0x2D), decimal magnitude digits (0x30-0x39) with no leading zeros, then line terminator.
REQ-013: Value 0 SHALL emit "0"; positive values SHALL emit no '+'; -2097152 SHALL emit "-2097152".
REQ-014: Input transfer SHALL occur on an edge with in_valid && in_ready; in_ready SHALL equal FIFO not full, independent of in_valid.
REQ-015: Output transfer SHALL occur on an edge with out_valid && out_ready; out_data SHALL stay stable while out_valid && !out_ready.
REQ-016: FSM states SHALL be IDLE, CONV, SIGN, DIGIT, TERM.
REQ-017: IDLE: if FIFO non-empty, pop head, latch sign and 22-bit unsigned magnitude, go CONV.
REQ-018: CONV SHALL run exactly 22 cycles of shift-add-3 binary-to-BCD into 7 BCD digits, then go SIGN if negative, else DIGIT.
REQ-019: SIGN SHALL present 0x2D; on transfer go DIGIT.
REQ-020: DIGIT SHALL present digits most-significant first, skipping leading zeros, always presenting the least-significant digit; after the last digit's transfer go TERM.
REQ-021: TERM SHALL present terminator byte(s); after the final terminator transfer increment line_count and go IDLE.
REQ-022: With idle FSM and empty FIFO, first out_valid SHALL assert 23 cycles after the accepting edge (pop on next edge, 22 CONV edges).
REQ-023: out_valid SHALL be low in IDLE and CONV and high in SIGN, DIGIT, TERM.
REQ-024: Push while popping in the same cycle SHALL be allowed when not full; a sample popped in IDLE frees a slot visible the next cycle.
REQ-025: No sample SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-026: rst_n low SHALL immediately force FSM to IDLE, empty the FIFO, clear BCD/sign registers and line_count.
REQ-027: During and after reset: out_valid=0, out_data=0x00, in_ready=0 while rst_n low then 1, busy=0, line_count=0.
REQ-028: Reset mid-line SHALL discard the partial line; no terminator SHALL be emitted for it.

Configuration
REQ-029: Macro SAMPLE_TEXT_WRITER_CRLF_EN defined SHALL make TERM emit 0x0D then 0x0A (two transfers); undefined SHALL make TERM emit 0x0A only.
REQ-030: line_count SHALL increment only after the 0x0A transfer in both builds.

Verification
REQ-031: Reset, push 0, out_ready=1 -> bytes 0x30,0x0A; first out_valid 23 cycles after accept; line_count=1.
REQ-032: Push -2097152 then 2097151 -> "-2097152\n2097151\n" byte-exact, line_count=2.
REQ-033: Push 7, out_ready toggled 1-in-3 -> out_data held stable while stalled; bytes 0x37,0x0A.
REQ-034: out_ready=0, push DEPTH+2 samples with in_valid held -> in_ready falls after DEPTH accepts (plus one popped to FSM); release -> all samples emitted in order.
REQ-035: Push -45, assert rst_n low after '-' transferred -> out_valid=0 immediately, no further bytes, line_count=0, busy=0.
REQ-036: Build with SAMPLE_TEXT_WRITER_CRLF_EN, push 10 -> 0x31,0x30,0x0D,0x0A; line_count=1.
